// File: rtl/filter_ctrl_pkg.sv
// Shared types and constant kernels for the filter mode controller.
package filter_ctrl_pkg;

    typedef enum logic [2:0] {
        BYPASS  = 3'd0,
        THRESH  = 3'd1,
        BRIGHT  = 3'd2,
        SOBEL_X = 3'd3,
        SOBEL_Y = 3'd4,
        SHARPEN = 3'd5
    } mode_e;

    typedef logic signed [7:0] kernel_t [0:2][0:2];

    localparam kernel_t K_IDENTITY = '{'{8'sd0, 8'sd0, 8'sd0},
                                       '{8'sd0, 8'sd1, 8'sd0},
                                       '{8'sd0, 8'sd0, 8'sd0}};
    localparam kernel_t K_SOBEL_X  = '{'{-8'sd1, 8'sd0, 8'sd1},
                                       '{-8'sd2, 8'sd0, 8'sd2},
                                       '{-8'sd1, 8'sd0, 8'sd1}};
    localparam kernel_t K_SOBEL_Y  = '{'{-8'sd1, -8'sd2, -8'sd1},
                                       '{ 8'sd0,  8'sd0,  8'sd0},
                                       '{ 8'sd1,  8'sd2,  8'sd1}};
    localparam kernel_t K_SHARPEN  = '{'{ 8'sd0, -8'sd1,  8'sd0},
                                       '{-8'sd1,  8'sd5, -8'sd1},
                                       '{ 8'sd0, -8'sd1,  8'sd0}};

    // Wrapping increment; any out-of-range index also wraps to 0.
    function automatic logic [2:0] next_mode(input logic [2:0] cur,
                                             input int unsigned num_modes);
        if ({29'd0, cur} + 32'd1 >= num_modes)
            return '0;
        return cur + 3'd1;
    endfunction

endpackage

// File: rtl/filter_mode_controller_debounce.sv
// Push-button synchroniser and debounce FSM; one press pulse per physical press.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LOAD = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] PRESS_WAIT   = 2'd1;
    localparam logic [1:0] HELD         = 2'd2;
    localparam logic [1:0] RELEASE_WAIT = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          sync1;
    logic          key_s;

    // The entry sample counts as the first stable cycle, hence LOAD = N-1.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1 <= 1'b1;
            key_s <= 1'b1;
            state <= IDLE;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= key_n;
            key_s <= sync1;
            press <= 1'b0;
            case (state)
                IDLE: begin
                    if (!key_s) begin
                        cnt   <= LOAD;
                        state <= PRESS_WAIT;
                    end
                end
                PRESS_WAIT: begin
                    if (key_s) begin
                        state <= IDLE;
                    end else if (cnt <= CW'(1)) begin
                        press <= 1'b1;
                        state <= HELD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HELD: begin
                    if (key_s) begin
                        cnt   <= LOAD;
                        state <= RELEASE_WAIT;
                    end
                end
                RELEASE_WAIT: begin
                    if (!key_s) begin
                        state <= HELD;
                    end else if (cnt <= CW'(1)) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/filter_mode_controller.sv
// Frame-synchronous display mode sequencer for the pixel filter pipeline.
// Optional beat-driven auto advance: define FILTER_AUTO_CYCLE_EN.
import filter_ctrl_pkg::*;

module filter_mode_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned NUM_MODES       = 6,
    parameter int unsigned BEATS_PER_MODE  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mode_key_n,
    input  logic              vsync,
    input  logic              beat_pulse,
    output logic              thresh_en,
    output logic              bright_en,
    output logic              adsr_en,
    output logic signed [7:0] k11,
    output logic signed [7:0] k12,
    output logic signed [7:0] k13,
    output logic signed [7:0] k21,
    output logic signed [7:0] k22,
    output logic signed [7:0] k23,
    output logic signed [7:0] k31,
    output logic signed [7:0] k32,
    output logic signed [7:0] k33,
    output logic [2:0]        mode_idx,
    output logic              commit_pulse
);

    logic       press_btn;
    logic       press_any;
    logic       vsync_q;
    logic       beat_q;
    logic       frame_start;
    logic [2:0] pending_mode;
    kernel_t    kern;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clk   (clk),
        .reset (reset),
        .key_n (mode_key_n),
        .press (press_btn)
    );

    assign frame_start = vsync & ~vsync_q;

`ifdef FILTER_AUTO_CYCLE_EN
    localparam int unsigned BW = (BEATS_PER_MODE > 1) ? $clog2(BEATS_PER_MODE) : 1;

    logic [BW-1:0] beat_cnt;
    logic          beat_rise;
    logic          auto_press;

    assign beat_rise  = beat_pulse & ~beat_q;
    assign auto_press = beat_rise && (beat_cnt == BW'(BEATS_PER_MODE - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            beat_cnt <= '0;
        end else if (beat_rise) begin
            beat_cnt <= auto_press ? '0 : beat_cnt + 1'b1;
        end
    end

    // A coincident button press and auto press still advance by one.
    assign press_any = press_btn | auto_press;
`else
    logic unused_beats;
    assign unused_beats = ^BEATS_PER_MODE;
    assign press_any    = press_btn;
`endif

    // Non-blocking update means a same-cycle press is not seen by the commit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            vsync_q      <= 1'b1;
            beat_q       <= 1'b0;
            pending_mode <= '0;
            mode_idx     <= '0;
            commit_pulse <= 1'b0;
        end else begin
            vsync_q      <= vsync;
            beat_q       <= beat_pulse;
            commit_pulse <= 1'b0;
            if (press_any)
                pending_mode <= next_mode(pending_mode, NUM_MODES);
            if (frame_start && (pending_mode != mode_idx)) begin
                mode_idx     <= pending_mode;
                commit_pulse <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            thresh_en <= 1'b0;
            bright_en <= 1'b0;
            adsr_en   <= 1'b0;
            kern      <= K_IDENTITY;
        end else begin
            thresh_en <= (mode_idx == THRESH);
            bright_en <= (mode_idx == BRIGHT);
            adsr_en   <= beat_q && (mode_idx != 3'd0);
            case (mode_idx)
                SOBEL_X: kern <= K_SOBEL_X;
                SOBEL_Y: kern <= K_SOBEL_Y;
                SHARPEN: kern <= K_SHARPEN;
                default: kern <= K_IDENTITY;
            endcase
        end
    end

    assign k11 = kern[0][0];
    assign k12 = kern[0][1];
    assign k13 = kern[0][2];
    assign k21 = kern[1][0];
    assign k22 = kern[1][1];
    assign k23 = kern[1][2];
    assign k31 = kern[2][0];
    assign k32 = kern[2][1];
    assign k33 = kern[2][2];

endmodule
